// File: rtl/ball_flow_sequencer_if.sv
// Board-side bundle for the ball sequencer: run control and bottom/interceptor events in, release pulses and run status out.
// master drives start and ball events; slave (the sequencer) drives releases and status.
interface ball_flow_sequencer_if #(
  parameter int CW         = 5,
  parameter int TRAY_DEPTH = 16
);
  logic                  start;
  logic                  blue_trigger;
  logic                  red_trigger;
  logic                  intercepted;
  logic                  blue_release;
  logic                  red_release;
  logic                  colour;
  logic                  busy;
  logic                  stopped;
  logic [1:0]            stop_reason;
  logic [CW-1:0]         blue_left;
  logic [CW-1:0]         red_left;
  logic [CW-1:0]         tray_count;
  logic [TRAY_DEPTH-1:0] tray_bits;

  modport master (
    output start, blue_trigger, red_trigger, intercepted,
    input  blue_release, red_release, colour, busy, stopped, stop_reason,
    input  blue_left, red_left, tray_count, tray_bits
  );

  modport slave (
    input  start, blue_trigger, red_trigger, intercepted,
    output blue_release, red_release, colour, busy, stopped, stop_reason,
    output blue_left, red_left, tray_count, tray_bits
  );
endinterface

// File: rtl/ball_flow_sequencer.sv
// Sequences one board run: releases balls, tracks the tray and stops on catch, empty reservoir or lost ball; start/trigger -> release pulse 2 edges later.
// No backpressure: inputs are events sampled each cycle and ignored outside the states that consume them.
module ball_flow_sequencer #(
  parameter int BLUE_BALLS = 8,
  parameter int RED_BALLS  = 8,
  parameter int CW         = 5,
  parameter int TIMEOUT    = 64,
  parameter int TRAY_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ball_flow_sequencer_if.slave   bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RELEASE, IN_FLIGHT, STOPPED} state_t;

  state_t                state_q, state_d;
  logic                  req_colour_q, req_colour_d;
  logic                  colour_q, colour_d;
  logic                  blue_rel_q, blue_rel_d;
  logic                  red_rel_q, red_rel_d;
  logic                  busy_q, busy_d;
  logic                  stopped_q, stopped_d;
  logic [1:0]            reason_q, reason_d;
  logic [CW-1:0]         blue_left_q, blue_left_d;
  logic [CW-1:0]         red_left_q, red_left_d;
  logic [CW-1:0]         tray_count_q, tray_count_d;
  logic [TRAY_DEPTH-1:0] tray_bits_q, tray_bits_d;
  logic [TW-1:0]         timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_colour_q <= 1'b0;
      colour_q     <= 1'b0;
      blue_rel_q   <= 1'b0;
      red_rel_q    <= 1'b0;
      busy_q       <= 1'b0;
      stopped_q    <= 1'b0;
      reason_q     <= 2'b00;
      blue_left_q  <= CW'(BLUE_BALLS);
      red_left_q   <= CW'(RED_BALLS);
      tray_count_q <= '0;
      tray_bits_q  <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_colour_q <= req_colour_d;
      colour_q     <= colour_d;
      blue_rel_q   <= blue_rel_d;
      red_rel_q    <= red_rel_d;
      busy_q       <= busy_d;
      stopped_q    <= stopped_d;
      reason_q     <= reason_d;
      blue_left_q  <= blue_left_d;
      red_left_q   <= red_left_d;
      tray_count_q <= tray_count_d;
      tray_bits_q  <= tray_bits_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_colour_d = req_colour_q;
    colour_d     = colour_q;
    blue_rel_d   = 1'b0;
    red_rel_d    = 1'b0;
    reason_d     = reason_q;
    blue_left_d  = blue_left_q;
    red_left_d   = red_left_q;
    tray_count_d = tray_count_q;
    tray_bits_d  = tray_bits_q;
    timer_d      = timer_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = RELEASE;
          req_colour_d = 1'b0;
        end
      end

      STOPPED: begin
        if (bus.start) begin
          state_d      = RELEASE;
          req_colour_d = 1'b0;
          reason_d     = 2'b00;
          blue_left_d  = CW'(BLUE_BALLS);
          red_left_d   = CW'(RED_BALLS);
          tray_count_d = '0;
          tray_bits_d  = '0;
        end
      end

      RELEASE: begin
        if (req_colour_q && (red_left_q != '0)) begin
          red_rel_d  = 1'b1;
          red_left_d = red_left_q - CW'(1);
          colour_d   = 1'b1;
          timer_d    = '0;
          state_d    = IN_FLIGHT;
        end else if (!req_colour_q && (blue_left_q != '0)) begin
          blue_rel_d  = 1'b1;
          blue_left_d = blue_left_q - CW'(1);
          colour_d    = 1'b0;
          timer_d     = '0;
          state_d     = IN_FLIGHT;
        end else begin
          reason_d = 2'b10;
          state_d  = STOPPED;
        end
      end

      IN_FLIGHT: begin
        timer_d = timer_q + TW'(1);
        // Interceptor beats triggers, and any event beats the timeout.
        if (bus.intercepted) begin
          reason_d = 2'b01;
          state_d  = STOPPED;
        end else if (bus.blue_trigger || bus.red_trigger) begin
          if (!(&tray_count_q))
            tray_count_d = tray_count_q + CW'(1);
          tray_bits_d  = {tray_bits_q[TRAY_DEPTH-2:0], colour_q};
          req_colour_d = !bus.blue_trigger;
          state_d      = RELEASE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          reason_d = 2'b11;
          state_d  = STOPPED;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d    = (state_d == RELEASE) || (state_d == IN_FLIGHT);
    stopped_d = (state_d == STOPPED);
  end

  assign bus.blue_release = blue_rel_q;
  assign bus.red_release  = red_rel_q;
  assign bus.colour       = colour_q;
  assign bus.busy         = busy_q;
  assign bus.stopped      = stopped_q;
  assign bus.stop_reason  = reason_q;
  assign bus.blue_left    = blue_left_q;
  assign bus.red_left     = red_left_q;
  assign bus.tray_count   = tray_count_q;
  assign bus.tray_bits    = tray_bits_q;
endmodule

// File: doc/ball_flow_sequencer.md
Name: ball_flow_sequencer

Overview:
- Clocked controller that sequences one Turing-Tumble board run.
- Owns the blue and red ball reservoirs and issues one-ball release pulses.
- Waits for each ball to reach a bottom trigger or the interceptor, keeps the tray record, and declares the run stopped: interceptor catch, empty reservoir, or lost-ball timeout.
- Sits between the puzzle's lever/interceptor outputs and the board's ball-release inputs.

Parameters:
- BLUE_BALLS, 8: initial blue reservoir count.
- RED_BALLS, 8: initial red reservoir count.
- CW, 5: width of reservoir/tray counters; must hold BLUE_BALLS+RED_BALLS.
- TIMEOUT, 64: max cycles a ball may stay in flight (must be ≥2).
- TRAY_DEPTH, 16: depth of colour history shift register.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin/restart run (sampled high for one or more cycles).
- blue_trigger  input  1  ball reached blue lever at bottom.
- red_trigger  input  1  ball reached red lever at bottom.
- intercepted  input  1  interceptor caught a ball.
- blue_release  output  1  one-cycle pulse: drop one blue ball.
- red_release  output  1  one-cycle pulse: drop one red ball.
- colour  output  1  colour of ball in flight / last released (0 blue, 1 red).
- busy  output  1  run in progress.
- stopped  output  1  run ended.
- stop_reason  output  2  00 none, 01 intercepted, 10 no balls, 11 timeout.
- blue_left  output  CW  blue balls remaining.
- red_left  output  CW  red balls remaining.
- tray_count  output  CW  balls landed in tray this run.
- tray_bits  output  TRAY_DEPTH  colour history, bit0 = newest.

Behaviour:
- One clock, asynchronous active-low reset; all outputs registered.
- Reset: state IDLE, release pulses 0, colour 0, busy 0, stopped 0, stop_reason 00, blue_left=BLUE_BALLS, red_left=RED_BALLS, tray_count 0, tray_bits 0, timer 0. Reset asserted mid-run aborts immediately; no release pulse completes.
- States: IDLE, RELEASE, IN_FLIGHT, STOPPED. req_colour is an internal register.
- IDLE: start=1 → RELEASE, req_colour=0 (blue).
- STOPPED: start=1 → reload reservoirs, clear tray_count/tray_bits/stop_reason, then → RELEASE with req_colour=0.
- RELEASE (one cycle):
  - Requested reservoir nonzero: assert the matching release pulse for exactly one cycle, decrement that reservoir, set colour=req_colour, clear timer, → IN_FLIGHT.
  - Requested reservoir zero: no pulse, stop_reason=10, → STOPPED.
- IN_FLIGHT: timer increments each cycle. Checks in priority order:
  - intercepted → STOPPED, reason 01; ball not counted in tray.
  - blue_trigger → tray_count+1 (saturating at 2^CW−1), tray_bits shifted left with colour in bit0, req_colour=0, → RELEASE.
  - red_trigger → same tray update, req_colour=1, → RELEASE.
  - timer==TIMEOUT−1 with no event → STOPPED, reason 11.
- Both triggers in the same cycle: blue wins.
- intercepted with a trigger in the same cycle: intercept wins, no tray update.
- Event on the final timeout cycle: event wins over timeout.
- Latency:
  - start or trigger sampled at clock edge k → release pulse high during the cycle following edge k+1.
  - Minimum spacing between consecutive release pulses is 2 cycles.
- Ignored inputs:
  - Triggers and intercepted outside IN_FLIGHT.
  - start in RELEASE or IN_FLIGHT.
- Status outputs: busy=1 in RELEASE and IN_FLIGHT; stopped=1 only in STOPPED. blue_release and red_release are never high together.
- Counters never underflow. Reservoir counts change only on a release or a reload.

Test Plan:
- Reset then start=1 one cycle → blue_release high exactly one cycle, 2 edges after start; blue_left 8→7; colour=0; busy=1.
- In flight, pulse red_trigger → tray_count=1, tray_bits=…0001? No: tray_bits bit0=0 (blue ball landed). Then red_release pulse, red_left=7, colour=1. Next blue_trigger → tray_bits[1:0]=2'b01 (red newest), tray_count=2.
- BLUE_BALLS=2: start, then blue_trigger twice → third request finds blue_left=0, no pulse, stopped=1, stop_reason=10, tray_count=2.
- TIMEOUT=8, start with no further input → stopped asserted after 8 in-flight cycles, stop_reason=11. Repeat with a trigger on the 8th cycle → no timeout, release issued.
- intercepted and blue_trigger asserted the same cycle → stop_reason=01, tray_count unchanged, no release pulse. Then start → reservoirs reloaded to 8/8, tray cleared, blue_release pulsed.
- rst_n low while IN_FLIGHT → all outputs to reset values asynchronously, before the next clock edge. Triggers pulsed while in IDLE → no effect.
